// File: rtl/key_debounce_pkg.sv
// Shared definitions for the three-key debouncer: FSM encoding, default
// debounce length and the state-to-level mapping used by every channel.
package key_debounce_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned N_KEYS              = 3;

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // The debounced level stays high until a release has been fully accepted.
    function automatic logic state_level(input logic [1:0] st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, saturating stable-sample
// counter, 4-state accept/reject FSM and registered level/pulse outputs.
//
// state           | meaning
// ST_RELEASED     | key accepted as released, waiting for a pressed sample
// ST_PRESS_WAIT   | pressed samples seen, counting towards acceptance
// ST_PRESSED      | key accepted as pressed, waiting for a released sample
// ST_RELEASE_WAIT | released samples seen, counting towards acceptance
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk100_i,
    input  logic rst_i,
    input  logic key_i,
    output logic key_level_o,
    output logic key_press_o,
    output logic key_release_o
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             sample_pressed;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_last;
    logic             press_nxt;
    logic             release_nxt;

    // Raw key is active-low; the synchronizer idles at 1 (released).
    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key_i;
            sync_q2 <= sync_q1;
        end
    end

    assign sample_pressed = ~sync_q2;
    assign cnt_last       = (cnt == CNT_LAST);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            ST_RELEASED: begin
                if (sample_pressed) begin
                    state_nxt = ST_PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sample_pressed) begin
                    state_nxt = ST_RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt_last) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!sample_pressed) begin
                    state_nxt = ST_RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sample_pressed) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt_last) begin
                    state_nxt   = ST_RELEASED;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Level and pulses are registered from the next state so the level rises
    // in the same cycle as the press pulse.
    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_RELEASED;
            cnt           <= '0;
            key_level_o   <= 1'b0;
            key_press_o   <= 1'b0;
            key_release_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            key_level_o   <= state_level(state_nxt);
            key_press_o   <= press_nxt;
            key_release_o <= release_nxt;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Three independent push-button debouncers; each raw key bit is handled by
// its own key_debounce_ch instance.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk100_i,
    input  logic              rst_i,
    input  logic [N_KEYS-1:0] key_i,
    output logic [N_KEYS-1:0] key_level_o,
    output logic [N_KEYS-1:0] key_press_o,
    output logic [N_KEYS-1:0] key_release_o
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk100_i     (clk100_i),
            .rst_i        (rst_i),
            .key_i        (key_i[g]),
            .key_level_o  (key_level_o[g]),
            .key_press_o  (key_press_o[g]),
            .key_release_o(key_release_o[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES = 4: expected pulses
// are queued when a key edge is driven and checked when the DUT pulses.
module tb_key_debounce;

    localparam int unsigned DC  = 4;
    localparam int          LAT = DC + 3;

    typedef struct {
        int         cyc;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] level;
        string      tag;
    } exp_t;

    logic       clk100_i = 1'b0;
    logic       rst_i    = 1'b0;
    logic [2:0] key_i    = 3'b111;
    logic [2:0] key_level_o;
    logic [2:0] key_press_o;
    logic [2:0] key_release_o;

    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];

    key_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk100_i     (clk100_i),
        .rst_i        (rst_i),
        .key_i        (key_i),
        .key_level_o  (key_level_o),
        .key_press_o  (key_press_o),
        .key_release_o(key_release_o)
    );

    always #5 clk100_i = ~clk100_i;
    always @(posedge clk100_i) cyc <= cyc + 1;

    task automatic chk_bits(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk100_i);
        #1;
    endtask

    task automatic expect_pulse(input string tag, input logic [2:0] press,
                                input logic [2:0] rel, input logic [2:0] level);
        exp_t e;
        e.cyc   = cyc + LAT;
        e.press = press;
        e.rel   = rel;
        e.level = level;
        e.tag   = tag;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        chk_int({tag, "_pending"}, sb_q.size(), 0);
    endtask

    // Any pulse must match the oldest queued expectation.
    always @(negedge clk100_i) begin
        if ((key_press_o | key_release_o) !== 3'b000) begin
            if (sb_q.size() == 0) begin
                chk_bits("unexpected_press", key_press_o, 3'b000);
                chk_bits("unexpected_release", key_release_o, 3'b000);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk_int({e.tag, "_cycle"}, cyc, e.cyc);
                chk_bits({e.tag, "_press"}, key_press_o, e.press);
                chk_bits({e.tag, "_release"}, key_release_o, e.rel);
                chk_bits({e.tag, "_level"}, key_level_o, e.level);
            end
        end
    end

    initial begin
        tick(2);
        rst_i = 1'b1;
        key_i = 3'b000;
        #1;
        chk_bits("rst_level", key_level_o, 3'b000);
        chk_bits("rst_press", key_press_o, 3'b000);
        chk_bits("rst_release", key_release_o, 3'b000);
        tick(3);
        key_i = 3'b111;
        rst_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk_bits("idle_level", key_level_o, 3'b000);
        end

        // Clean press and release of key 0.
        key_i[0] = 1'b0;
        expect_pulse("press0", 3'b001, 3'b000, 3'b001);
        tick(20);
        drain("press0");
        chk_bits("press0_hold_level", key_level_o, 3'b001);
        key_i[0] = 1'b1;
        expect_pulse("release0", 3'b000, 3'b001, 3'b000);
        tick(20);
        drain("release0");
        chk_bits("release0_level", key_level_o, 3'b000);

        // Glitch on key 2 shorter than the debounce window.
        key_i[2] = 1'b0;
        tick(3);
        key_i[2] = 1'b1;
        tick(20);
        chk_bits("glitch2_level", key_level_o, 3'b000);

        // Bounce on key 1, then it settles low.
        for (int i = 0; i < 6; i++) begin
            key_i[1] = ~key_i[1];
            tick(1);
        end
        key_i[1] = 1'b0;
        expect_pulse("bounce1", 3'b010, 3'b000, 3'b010);
        tick(20);
        drain("bounce1");
        chk_bits("bounce1_level", key_level_o, 3'b010);
        key_i[1] = 1'b1;
        expect_pulse("bounce1_rel", 3'b000, 3'b010, 3'b000);
        tick(20);
        drain("bounce1_rel");

        // Simultaneous press and release on keys 0 and 1.
        key_i = 3'b100;
        expect_pulse("simul_press", 3'b011, 3'b000, 3'b011);
        tick(20);
        drain("simul_press");
        key_i = 3'b111;
        expect_pulse("simul_rel", 3'b000, 3'b011, 3'b000);
        tick(20);
        drain("simul_rel");
        chk_bits("simul_rel_level", key_level_o, 3'b000);

        // Reset mid-debounce on key 2, key held through reset release.
        key_i[2] = 1'b0;
        tick(2);
        rst_i = 1'b1;
        #1;
        chk_bits("midrst_level", key_level_o, 3'b000);
        tick(2);
        rst_i = 1'b0;
        expect_pulse("midrst_press", 3'b100, 3'b000, 3'b100);
        tick(20);
        drain("midrst_press");
        key_i[2] = 1'b1;
        expect_pulse("midrst_rel", 3'b000, 3'b100, 3'b000);
        tick(20);
        drain("midrst_rel");
        chk_bits("final_level", key_level_o, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
